// File: rtl/sdk_pkg.sv
// Shared SDK package: weight-loader state encoding and the default weight
// geometry used by the control unit, the weight loader and the FP/BP engines.
package sdk_pkg;

  localparam int NUM_WEIGHTS_DEF = 64;
  localparam int W_WIDTH_DEF     = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    ACK  = 3'd3,
    HOLD = 3'd4
  } weight_loader_state_t;

endpackage

// File: rtl/weight_loader.sv
// weight_loader: on a level request from the control unit, reads weights
// 0..NUM_WEIGHTS-1 from weight memory one outstanding read at a time, writes
// each returned word into weight storage and pulses weights_ack together with
// the final write. HOLD keeps a request that stays high from starting a second
// load. All outputs are registered.
// Optional feature: define WEIGHT_LOADER_CHECKSUM_EN to accumulate a
// mod-2^W_WIDTH checksum of the loaded words; otherwise checksum is tied to 0.
module weight_loader
  import sdk_pkg::*;
#(
  parameter int NUM_WEIGHTS = NUM_WEIGHTS_DEF,
  parameter int W_WIDTH     = W_WIDTH_DEF,
  parameter int ADDR_W      = $clog2(NUM_WEIGHTS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               get_all_weights,
  output logic               weights_ack,
  output logic               busy,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_rvalid,
  input  logic [W_WIDTH-1:0] mem_rdata,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [W_WIDTH-1:0] wr_data,
  output logic [W_WIDTH-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHTS - 1);

  weight_loader_state_t r_state;
  weight_loader_state_t w_state_nxt;

  logic [ADDR_W-1:0]  r_idx;
  logic [ADDR_W-1:0]  w_idx_nxt;
  logic               w_rd_done;
  logic               w_last;

  logic               r_mem_req;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic               r_busy;
  logic               r_ack;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [W_WIDTH-1:0] r_wr_data;

  logic               w_mem_req_nxt;
  logic               w_busy_nxt;
  logic               w_ack_nxt;
  logic               w_wr_en_nxt;
  logic [ADDR_W-1:0]  w_wr_addr_nxt;
  logic [W_WIDTH-1:0] w_wr_data_nxt;

  // Read data is only meaningful while a read is outstanding.
  assign w_rd_done = (r_state == WAIT) && mem_rvalid;
  assign w_last    = (r_idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: walk REQ/WAIT per weight, ack once, then wait for the request to drop.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (get_all_weights) w_state_nxt = REQ;
      REQ:     w_state_nxt = WAIT;
      WAIT:    if (mem_rvalid) w_state_nxt = w_last ? ACK : REQ;
      ACK:     w_state_nxt = HOLD;
      HOLD:    if (!get_all_weights) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, derived from the state being entered.
  always_comb begin
    w_idx_nxt = r_idx;
    if (w_state_nxt == IDLE)
      w_idx_nxt = '0;
    else if (w_rd_done && !w_last)
      w_idx_nxt = r_idx + ADDR_W'(1);

    w_mem_req_nxt = (w_state_nxt == REQ);
    w_busy_nxt    = (w_state_nxt == REQ) || (w_state_nxt == WAIT) || (w_state_nxt == ACK);
    w_ack_nxt     = (w_state_nxt == ACK);
    w_wr_en_nxt   = w_rd_done;
    w_wr_addr_nxt = w_rd_done ? r_idx     : r_wr_addr;
    w_wr_data_nxt = w_rd_done ? mem_rdata : r_wr_data;
  end

  // Output and index registers; the address register tracks idx so it is valid whenever mem_req is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_idx      <= w_idx_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_idx_nxt;
      r_busy     <= w_busy_nxt;
      r_ack      <= w_ack_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign busy        = r_busy;
  assign weights_ack = r_ack;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [W_WIDTH-1:0] r_checksum;
  logic               w_start;

  assign w_start = (r_state == IDLE) && get_all_weights;

  // Checksum accumulator: cleared at load start, adds each word as it is registered for writing,
  // so the full sum is visible in the ack cycle and held until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_checksum <= '0;
    else if (w_start)   r_checksum <= '0;
    else if (w_rd_done) r_checksum <= r_checksum + mem_rdata;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Directed testbench for weight_loader (NUM_WEIGHTS=4, W_WIDTH=16) with a
// latency-programmable memory responder and a passive event monitor.
module tb_weight_loader;

  localparam int NW = 4;
  localparam int WW = 16;
  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic          get_all_weights;
  logic          weights_ack;
  logic          busy;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rvalid;
  logic [WW-1:0] mem_rdata;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic [WW-1:0] checksum;

  weight_loader #(.NUM_WEIGHTS(NW), .W_WIDTH(WW)) dut (
    .clk            (clk),
    .rst            (rst),
    .get_all_weights(get_all_weights),
    .weights_ack    (weights_ack),
    .busy           (busy),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .checksum       (checksum)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [WW-1:0] mem [NW];
  logic [WW-1:0] exp_ck;
  int   lat_a = 1;
  int   lat_b = 1;
  logic spur  = 1'b0;

  int   n_req = 0, n_wr = 0, n_ack = 0, n_rv = 0;
  int   dbl_req = 0, proto_err = 0, lag_err = 0, rv_cyc = -10;
  logic outst = 1'b0;
  logic [AW-1:0] req_a [256];
  logic [AW-1:0] wr_a  [256];
  logic [WW-1:0] wr_d  [256];
  logic          ack_wr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1);
  end

  // Memory responder: even addresses answer after lat_a cycles, odd after lat_b.
  initial begin : responder
    int            cnt;
    logic [AW-1:0] pa;
    logic          sp;
    cnt = 0;
    pa = '0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      sp = spur;
      if (mem_req === 1'b1) begin
        pa  = mem_addr;
        cnt = pa[0] ? lat_b : lat_a;
      end
      @(posedge clk);
      #1;
      mem_rvalid = sp;
      if (sp) mem_rdata = 16'hDEAD;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[pa];
        end
      end
    end
  end

  // Passive monitor, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (mem_req === 1'b1 && mem_rvalid === 1'b1) proto_err++;
    if (mem_req === 1'b1) begin
      if (outst) dbl_req++;
      outst = 1'b1;
      req_a[n_req % 256] = mem_addr;
      n_req++;
    end
    if (mem_rvalid === 1'b1) begin
      outst = 1'b0;
      rv_cyc = cyc;
      n_rv++;
    end
    if (wr_en === 1'b1) begin
      if (cyc != rv_cyc + 1) lag_err++;
      wr_a[n_wr % 256] = wr_addr;
      wr_d[n_wr % 256] = wr_data;
      n_wr++;
    end
    if (weights_ack === 1'b1) begin
      n_ack++;
      ack_wr = wr_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_ack(input string nm, output int acyc);
    int t = 0;
    while (weights_ack !== 1'b1 && t < 200) begin
      tick();
      t++;
    end
    check({nm, "_ack_seen"}, 32'(weights_ack), 1);
    acyc = cyc;
  endtask

  task automatic check_load(input string nm, input int rb, input int wb);
    check({nm, "_nreq"}, n_req - rb, 4);
    check({nm, "_nwr"}, n_wr - wb, 4);
    for (int i = 0; i < NW; i++) begin
      check({nm, "_req_addr"}, 32'(req_a[(rb + i) % 256]), i);
      check({nm, "_wr_addr"}, 32'(wr_a[(wb + i) % 256]), i);
      check({nm, "_wr_data"}, 32'(wr_d[(wb + i) % 256]), 32'(mem[i]));
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_busy"},     32'(busy), 0);
    check({nm, "_mem_req"},  32'(mem_req), 0);
    check({nm, "_mem_addr"}, 32'(mem_addr), 0);
    check({nm, "_wr_en"},    32'(wr_en), 0);
    check({nm, "_wr_addr"},  32'(wr_addr), 0);
    check({nm, "_wr_data"},  32'(wr_data), 0);
    check({nm, "_ack"},      32'(weights_ack), 0);
    check({nm, "_checksum"}, 32'(checksum), 0);
  endtask

  initial begin : main
    int e0, acyc, wb, rb, ab, rvb, t, bad;
    rst = 1'b1;
    get_all_weights = 1'b0;
    for (int i = 0; i < NW; i++) mem[i] = WW'(16'h10 + i);
    exp_ck = '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    for (int i = 0; i < NW; i++) exp_ck = exp_ck + mem[i];
`endif

    ticks(3);
    check_all_zero("reset");
    rst = 1'b0;
    ticks(2);

    // Basic load, L=1
    lat_a = 1; lat_b = 1;
    wb = n_wr; rb = n_req; ab = n_ack;
    get_all_weights = 1'b1;
    e0 = cyc + 1;
    wait_ack("basic", acyc);
    check("basic_ack_cycle", acyc - e0, 8);
    check("basic_ack_busy", 32'(busy), 1);
    check("basic_ack_checksum", 32'(checksum), 32'(exp_ck));
    get_all_weights = 1'b0;
    tick();
    check("basic_hold_busy", 32'(busy), 0);
    check("basic_hold_ack", 32'(weights_ack), 0);
    ticks(2);
    check_load("basic", rb, wb);
    check("basic_ack_with_wr", 32'(ack_wr), 1);
    check("basic_nack", n_ack - ab, 1);
    check("basic_checksum_held", 32'(checksum), 32'(exp_ck));

    // Variable latency: 1,3,1,3
    lat_a = 1; lat_b = 3;
    wb = n_wr; rb = n_req;
    get_all_weights = 1'b1;
    e0 = cyc + 1;
    wait_ack("varlat", acyc);
    check("varlat_ack_cycle", acyc - e0, 12);
    check("varlat_ack_checksum", 32'(checksum), 32'(exp_ck));
    get_all_weights = 1'b0;
    ticks(3);
    check_load("varlat", rb, wb);
    check("varlat_double_req", dbl_req, 0);
    check("varlat_wr_lag", lag_err, 0);

    // Held request
    lat_a = 1; lat_b = 1;
    wb = n_wr; rb = n_req; ab = n_ack;
    get_all_weights = 1'b1;
    wait_ack("held", acyc);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy !== 1'b0 || mem_req !== 1'b0) bad++;
    end
    check("held_quiet", bad, 0);
    check("held_nack", n_ack - ab, 1);
    check_load("held", rb, wb);
    get_all_weights = 1'b0;
    ticks(2);
    get_all_weights = 1'b1;
    tick();
    check("held_restart_req", 32'(mem_req), 1);
    check("held_restart_addr", 32'(mem_addr), 0);
    wait_ack("held_restart", acyc);
    get_all_weights = 1'b0;
    ticks(3);

    // Early drop after the second request
    wb = n_wr; rb = n_req; ab = n_ack;
    get_all_weights = 1'b1;
    t = 0;
    while (n_req - rb < 2 && t < 50) begin
      tick();
      t++;
    end
    check("early_second_req", n_req - rb, 2);
    get_all_weights = 1'b0;
    wait_ack("early", acyc);
    tick();
    check("early_hold_busy", 32'(busy), 0);
    check_load("early", rb, wb);
    check("early_nack", n_ack - ab, 1);
    tick();
    get_all_weights = 1'b1;
    tick();
    check("early_min_gap_req", 32'(mem_req), 1);
    check("early_min_gap_addr", 32'(mem_addr), 0);
    wait_ack("early_next", acyc);
    get_all_weights = 1'b0;
    ticks(3);

    // Reset during WAIT for idx 2
    lat_a = 3; lat_b = 3;
    ab = n_ack;
    get_all_weights = 1'b1;
    t = 0;
    while (!(mem_req === 1'b1 && mem_addr == 2'd2) && t < 100) begin
      tick();
      t++;
    end
    check("rstmid_reached_idx2", 32'(mem_addr), 2);
    tick();
    rst = 1'b1;
    get_all_weights = 1'b0;
    #1;
    check_all_zero("rstmid");
    tick();
    rst = 1'b0;
    wb = n_wr; rvb = n_rv;
    ticks(6);
    check("rstmid_stray_rvalid", n_rv - rvb, 1);
    check("rstmid_no_wr", n_wr - wb, 0);
    check("rstmid_no_ack", n_ack - ab, 0);
    check("rstmid_idle_busy", 32'(busy), 0);
    lat_a = 1; lat_b = 1;
    wb = n_wr; rb = n_req;
    get_all_weights = 1'b1;
    tick();
    check("rstmid_restart_req", 32'(mem_req), 1);
    check("rstmid_restart_addr", 32'(mem_addr), 0);
    wait_ack("rstmid_restart", acyc);
    check("rstmid_restart_checksum", 32'(checksum), 32'(exp_ck));
    get_all_weights = 1'b0;
    ticks(3);
    check_load("rstmid_restart", rb, wb);

    // Spurious read data in IDLE and in HOLD
    wb = n_wr; rb = n_req; rvb = n_rv;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    ticks(3);
    check("spur_idle_rvalid", n_rv - rvb, 1);
    check("spur_idle_wr", n_wr - wb, 0);
    check("spur_idle_req", n_req - rb, 0);
    check("spur_idle_busy", 32'(busy), 0);
    wb = n_wr; rb = n_req; ab = n_ack;
    get_all_weights = 1'b1;
    wait_ack("spur_hold", acyc);
    tick();
    rvb = n_rv;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    ticks(3);
    check("spur_hold_rvalid", n_rv - rvb, 1);
    check_load("spur_hold", rb, wb);
    check("spur_hold_nack", n_ack - ab, 1);
    check("spur_hold_busy", 32'(busy), 0);
    get_all_weights = 1'b0;
    ticks(3);

    check("protocol_rvalid_with_req", proto_err, 0);
    check("double_req_total", dbl_req, 0);
    check("wr_lag_total", lag_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
